// File: rtl/spi_xfer_sequencer_if.sv
// Wishbone master/slave bundle between spi_xfer_sequencer and the spi_top register port.
// Signal names keep the master-side _o/_i suffixes of the spi_top bus.
interface spi_xfer_sequencer_if;
   logic [4:0]  wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_int_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
      input  wb_dat_i, wb_ack_i, wb_int_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
      output wb_dat_i, wb_ack_i, wb_int_i
   );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Runs one full spi_top transfer per request: CTRL, DIVIDER, SS, TX0, CTRL|GO,
// wait for the core interrupt, read RX0 back and hand the word to the client.
module spi_xfer_sequencer #(
   parameter int SS_NB   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic                 wb_clk_in,
   input  logic                 wb_rst_in,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [31:0]          req_data,
   input  logic [6:0]           req_len,
   input  logic [SS_NB-1:0]     req_ss,
   input  logic [15:0]          req_div,
   input  logic                 req_lsb,
   input  logic                 req_tx_neg,
   input  logic                 req_rx_neg,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_data,
   output logic                 rsp_err,
   spi_xfer_sequencer_if.master wb
);

   localparam logic [4:0]  ADR_TX0  = 5'h00;
   localparam logic [4:0]  ADR_CTRL = 5'h10;
   localparam logic [4:0]  ADR_DIV  = 5'h14;
   localparam logic [4:0]  ADR_SS   = 5'h18;
   localparam logic [31:0] CTRL_GO  = 32'h0000_0100;
   localparam int          CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_CTRL,
      S_WR_DIV,
      S_WR_SS,
      S_WR_TX,
      S_WR_GO,
      S_WAIT_INT,
      S_RD_RX,
      S_RESP
   } state_t;

   state_t            state;
   state_t            succ;
   logic [13:0]       ctrl_q;
   logic [15:0]       div_q;
   logic [SS_NB-1:0]  ss_q;
   logic [31:0]       data_q;
   logic [CNT_W-1:0]  tmo_cnt;
   logic              gap;

   logic [13:0]       req_ctrl;
   logic [31:0]       ss_word;
   logic [4:0]        launch_adr;
   logic [31:0]       launch_dat;
   logic              launch_we;

   // CTRL image without GO: ass, ie, lsb, tx_neg, rx_neg, go=0, reserved, char_len.
   assign req_ctrl = {1'b1, 1'b1, req_lsb, req_tx_neg, req_rx_neg, 1'b0, 1'b0, req_len};

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      succ = S_IDLE;
      case (state)
         S_IDLE:     succ = S_WR_CTRL;
         S_WR_CTRL:  succ = S_WR_DIV;
         S_WR_DIV:   succ = S_WR_SS;
         S_WR_SS:    succ = S_WR_TX;
         S_WR_TX:    succ = S_WR_GO;
         S_WR_GO:    succ = S_WAIT_INT;
         S_WAIT_INT: succ = S_RD_RX;
         S_RD_RX:    succ = S_RESP;
         default:    succ = S_IDLE;
      endcase
   end

   always_comb begin
      ss_word              = '0;
      ss_word[SS_NB-1:0]   = ss_q;
   end

   // Bus fields of the access that the successor state performs.  The CTRL write is
   // launched on the accept edge, so it takes the live request, not the latched copy.
   always_comb begin
      launch_adr = '0;
      launch_dat = '0;
      launch_we  = 1'b1;
      case (succ)
         S_WR_CTRL: begin
            launch_adr = ADR_CTRL;
            launch_dat = {18'b0, req_ctrl};
         end
         S_WR_DIV: begin
            launch_adr = ADR_DIV;
            launch_dat = {16'b0, div_q};
         end
         S_WR_SS: begin
            launch_adr = ADR_SS;
            launch_dat = ss_word;
         end
         S_WR_TX: begin
            launch_adr = ADR_TX0;
            launch_dat = data_q;
         end
         S_WR_GO: begin
            launch_adr = ADR_CTRL;
            launch_dat = {18'b0, ctrl_q} | CTRL_GO;
         end
         S_RD_RX: begin
            launch_adr = ADR_TX0;
            launch_we  = 1'b0;
         end
         default: launch_we = 1'b0;
      endcase
   end

   // NOTE: all state and outputs here use non-blocking assignments so every read in this
   // block sees the pre-edge value regardless of statement order.
   always_ff @(posedge wb_clk_in) begin
      if (!wb_rst_in) begin
         state       <= S_IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_data    <= '0;
         wb.wb_cyc_o <= 1'b0;
         wb.wb_stb_o <= 1'b0;
         wb.wb_we_o  <= 1'b0;
         wb.wb_adr_o <= '0;
         wb.wb_dat_o <= '0;
         wb.wb_sel_o <= '0;
         tmo_cnt     <= '0;
         gap         <= 1'b0;
         ctrl_q      <= '0;
         div_q       <= '0;
         ss_q        <= '0;
         data_q      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  ctrl_q      <= req_ctrl;
                  div_q       <= req_div;
                  ss_q        <= req_ss;
                  data_q      <= req_data;
                  req_ready   <= 1'b0;
                  state       <= S_WR_CTRL;
                  wb.wb_cyc_o <= 1'b1;
                  wb.wb_stb_o <= 1'b1;
                  wb.wb_sel_o <= 4'hF;
                  wb.wb_adr_o <= launch_adr;
                  wb.wb_dat_o <= launch_dat;
                  wb.wb_we_o  <= launch_we;
               end
            end

            // Each write ends with one idle bus cycle (gap) before the next state launches.
            S_WR_CTRL, S_WR_DIV, S_WR_SS, S_WR_TX, S_WR_GO: begin
               if (wb.wb_cyc_o && wb.wb_ack_i) begin
                  wb.wb_cyc_o <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  wb.wb_sel_o <= '0;
                  wb.wb_adr_o <= '0;
                  wb.wb_dat_o <= '0;
                  wb.wb_we_o  <= 1'b0;
                  gap         <= 1'b1;
               end else if (gap) begin
                  gap   <= 1'b0;
                  state <= succ;
                  if (succ != S_WAIT_INT) begin
                     wb.wb_cyc_o <= 1'b1;
                     wb.wb_stb_o <= 1'b1;
                     wb.wb_sel_o <= 4'hF;
                     wb.wb_adr_o <= launch_adr;
                     wb.wb_dat_o <= launch_dat;
                     wb.wb_we_o  <= launch_we;
                  end
               end
            end

            S_WAIT_INT: begin
               if (wb.wb_int_i) begin
                  tmo_cnt     <= '0;
                  state       <= S_RD_RX;
                  wb.wb_cyc_o <= 1'b1;
                  wb.wb_stb_o <= 1'b1;
                  wb.wb_sel_o <= 4'hF;
                  wb.wb_adr_o <= launch_adr;
                  wb.wb_dat_o <= launch_dat;
                  wb.wb_we_o  <= launch_we;
               end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                  tmo_cnt   <= '0;
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end

            // The RX0 read also clears the core interrupt, so no extra access is needed.
            S_RD_RX: begin
               if (wb.wb_cyc_o && wb.wb_ack_i) begin
                  wb.wb_cyc_o <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  wb.wb_sel_o <= '0;
                  wb.wb_adr_o <= '0;
                  wb.wb_dat_o <= '0;
                  wb.wb_we_o  <= 1'b0;
                  rsp_data    <= wb.wb_dat_i;
                  rsp_err     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= S_RESP;
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer against a small spi_top loopback register model.
// All expected bus words and results are hand-computed constants.
module tb_spi_xfer_sequencer;
   localparam int SS_NB   = 8;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [31:0] req_data;
   logic [6:0]  req_len;
   logic [7:0]  req_ss;
   logic [15:0] req_div;
   logic        req_lsb, req_tx_neg, req_rx_neg;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_data;

   spi_xfer_sequencer_if bus ();

   spi_xfer_sequencer #(.SS_NB(SS_NB), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_in  (clk),
      .wb_rst_in  (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_len    (req_len),
      .req_ss     (req_ss),
      .req_div    (req_div),
      .req_lsb    (req_lsb),
      .req_tx_neg (req_tx_neg),
      .req_rx_neg (req_rx_neg),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .wb         (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Slave model: zero or wait_n wait states, loopback RX0 = TX0 masked to char_len,
   // interrupt raised 4 cycles after a GO write and cleared by reading RX0.
   int          cyc_cnt = 0;
   int          wait_n  = 0;
   bit          int_en  = 1'b1;
   int          wcnt    = 0;
   int          int_cnt = 0;
   int          stab_err = 0;
   logic [37:0] cur;
   logic [31:0] tx_reg  = '0;
   logic [6:0]  ctrl_len = '0;
   logic [37:0] log_q[$];
   int          start_q[$];
   int          ack_q[$];

   function automatic logic [31:0] len_mask(input logic [6:0] l);
      if (l == 7'd0 || l >= 7'd32) return 32'hFFFF_FFFF;
      return (32'h1 << l) - 32'h1;
   endfunction

   function automatic logic [37:0] wr(input logic [4:0] a, input logic [31:0] d);
      return {1'b1, a, d};
   endfunction

   always @(negedge clk) begin
      cyc_cnt++;
      if (int_cnt > 0) begin
         int_cnt--;
         if (int_cnt == 0 && int_en) bus.wb_int_i = 1'b1;
      end
      if (!rst_n) begin
         bus.wb_ack_i = 1'b0;
         bus.wb_int_i = 1'b0;
         bus.wb_dat_i = '0;
         wcnt         = 0;
         int_cnt      = 0;
      end else if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i) begin
         if (wcnt == 0) begin
            cur = {bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o};
            start_q.push_back(cyc_cnt);
         end else if ({bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} !== cur) begin
            stab_err++;
         end
         if (bus.wb_sel_o !== 4'hF) stab_err++;
         if (wcnt == wait_n + 1) begin
            bus.wb_ack_i = 1'b1;
            bus.wb_dat_i = '0;
            log_q.push_back(cur);
            ack_q.push_back(cyc_cnt);
            if (cur[37]) begin
               if (cur[36:32] == 5'h00) tx_reg = cur[31:0];
               if (cur[36:32] == 5'h10) begin
                  ctrl_len = cur[6:0];
                  if (cur[8]) int_cnt = 4;
               end
            end else begin
               bus.wb_dat_i = tx_reg & len_mask(ctrl_len);
               bus.wb_int_i = 1'b0;
            end
         end
         wcnt++;
      end else begin
         bus.wb_ack_i = 1'b0;
         wcnt         = 0;
      end
   end

   int acc_n, rsp_n, sbase, lbase, h;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Drives one request from a sample point in IDLE; returns at the first sample after accept
   // with the request fields scrambled so late changes would show up in the bus log.
   task automatic send(input logic [31:0] d, input logic [6:0] l, input logic [7:0] s,
                       input logic [15:0] dv, input logic lsb, input logic txn, input logic rxn);
      sbase      = start_q.size();
      lbase      = log_q.size();
      req_data   = d;
      req_len    = l;
      req_ss     = s;
      req_div    = dv;
      req_lsb    = lsb;
      req_tx_neg = txn;
      req_rx_neg = rxn;
      req_valid  = 1'b1;
      step();
      acc_n      = cyc_cnt;
      req_valid  = 1'b0;
      req_data   = ~d;
      req_len    = l ^ 7'h55;
      req_ss     = ~s;
      req_div    = ~dv;
      req_lsb    = ~lsb;
      req_tx_neg = ~txn;
      req_rx_neg = ~rxn;
   endtask

   task automatic wait_rsp(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (rsp_valid === 1'b1) break;
         step();
      end
      check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
      rsp_n = cyc_cnt;
   endtask

   task automatic check_xfer(input string tag, input logic [31:0] ctrl, input logic [31:0] dv,
                             input logic [31:0] s, input logic [31:0] d, input logic [31:0] go,
                             input bit with_read);
      logic [37:0] exp [6];
      exp[0] = wr(5'h10, ctrl);
      exp[1] = wr(5'h14, dv);
      exp[2] = wr(5'h18, s);
      exp[3] = wr(5'h00, d);
      exp[4] = wr(5'h10, go);
      exp[5] = {1'b0, 5'h00, 32'h0};
      check({tag, "_n_access"}, log_q.size() - lbase, with_read ? 6 : 5);
      for (int i = 0; i < (with_read ? 6 : 5); i++)
         check($sformatf("%s_access%0d", tag, i), log_q[lbase + i], exp[i]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"},
            {req_ready, rsp_valid, rsp_err, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
             bus.wb_sel_o, bus.wb_adr_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 5'h00});
      check({tag, "_data"}, {rsp_data, bus.wb_dat_o}, 64'h0);
   endtask

   initial begin
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_data     = '0;
      req_len      = '0;
      req_ss       = '0;
      req_div      = '0;
      req_lsb      = 1'b0;
      req_tx_neg   = 1'b0;
      req_rx_neg   = 1'b0;
      rsp_ready    = 1'b1;
      bus.wb_ack_i = 1'b0;
      bus.wb_int_i = 1'b0;
      bus.wb_dat_i = '0;

      repeat (3) step();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      step();

      // Core config: len 4, lsb, tx_neg
      send(32'h236F, 7'd4, 8'h01, 16'h0004, 1'b1, 1'b1, 1'b0);
      check("t1_ready_drop_stb", {req_ready, bus.wb_stb_o, bus.wb_cyc_o}, 3'b011);
      wait_rsp("t1");
      check("t1_rsp", {rsp_err, rsp_data}, {1'b0, 32'h0000_000F});
      check_xfer("t1", 32'h3C04, 32'h4, 32'h1, 32'h236F, 32'h3D04, 1'b1);
      check("t1_go_start", start_q[sbase + 4] - acc_n, 12);
      check("t1_rsp_latency", rsp_n - ack_q[lbase + 5], 1);
      step();
      check("t1_back_idle", {rsp_valid, req_ready}, 2'b01);

      // Mode variant: rx_neg instead of tx_neg
      send(32'h1234, 7'd4, 8'h02, 16'h0010, 1'b1, 1'b0, 1'b1);
      wait_rsp("t2");
      check("t2_rsp", {rsp_err, rsp_data}, {1'b0, 32'h0000_0004});
      check_xfer("t2", 32'h3A04, 32'h10, 32'h2, 32'h1234, 32'h3B04, 1'b1);
      step();

      // Wait-state slave: 3 extra cycles per access
      wait_n   = 3;
      stab_err = 0;
      send(32'h236F, 7'd4, 8'h01, 16'h0004, 1'b1, 1'b1, 1'b0);
      wait_rsp("t3");
      check("t3_rsp", {rsp_err, rsp_data}, {1'b0, 32'h0000_000F});
      check_xfer("t3", 32'h3C04, 32'h4, 32'h1, 32'h236F, 32'h3D04, 1'b1);
      check("t3_stable", stab_err, 0);
      check("t3_access_spacing", start_q[sbase + 1] - start_q[sbase], 6);
      wait_n = 0;
      step();

      // Timeout: no interrupt
      int_en = 1'b0;
      send(32'hFFFF_0000, 7'd8, 8'h04, 16'h0002, 1'b0, 1'b0, 1'b0);
      wait_rsp("t4");
      check("t4_rsp", {rsp_err, rsp_data}, {1'b1, 32'h0});
      check("t4_rsp_time", rsp_n - acc_n, 31);
      check_xfer("t4", 32'h3008, 32'h2, 32'h4, 32'hFFFF_0000, 32'h3108, 1'b0);
      int_en = 1'b1;
      step();

      // Backpressure then back-to-back request
      rsp_ready = 1'b0;
      send(32'hCAFE_BABE, 7'd16, 8'h80, 16'h0123, 1'b0, 1'b0, 1'b0);
      wait_rsp("t5");
      repeat (5) step();
      check("t5_held", {rsp_valid, rsp_err, rsp_data}, {1'b1, 1'b0, 32'h0000_BABE});
      check_xfer("t5", 32'h3010, 32'h123, 32'h80, 32'hCAFE_BABE, 32'h3110, 1'b1);
      h          = cyc_cnt;
      rsp_ready  = 1'b1;
      req_valid  = 1'b1;
      req_data   = 32'h0F0F_5A5A;
      req_len    = 7'd0;
      req_ss     = 8'h55;
      req_div    = 16'hFFFF;
      req_lsb    = 1'b0;
      req_tx_neg = 1'b1;
      req_rx_neg = 1'b1;
      sbase      = start_q.size();
      lbase      = log_q.size();
      step();
      check("t6_after_hs", {rsp_valid, req_ready}, 2'b01);
      step();
      req_valid = 1'b0;
      req_data  = 32'hDEAD_BEEF;
      req_len   = 7'd9;
      req_ss    = 8'hAA;
      req_div   = 16'h0;
      req_lsb   = 1'b1;
      check("t6_accept", {req_ready, bus.wb_stb_o}, 2'b01);
      check("t6_accept_time", start_q[sbase] - h, 2);
      wait_rsp("t6");
      check("t6_rsp", {rsp_err, rsp_data}, {1'b0, 32'h0F0F_5A5A});
      check_xfer("t6", 32'h3600, 32'hFFFF, 32'h55, 32'h0F0F_5A5A, 32'h3700, 1'b1);
      step();

      // Reset during WR_TX
      send(32'h236F, 7'd4, 8'h01, 16'h0004, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 50; i++) begin
         if (start_q.size() - sbase == 4) break;
         step();
      end
      check("t7_in_wr_tx", {start_q.size() - sbase, bus.wb_adr_o}, {32'd4, 5'h00});
      rst_n = 1'b0;
      step();
      check_reset_outputs("t7_reset");
      rst_n = 1'b1;
      repeat (6) step();
      check("t7_no_activity", {rsp_valid, start_q.size() - sbase}, {1'b0, 32'd4});

      // Reset during WAIT_INT
      int_en = 1'b0;
      send(32'h1234, 7'd4, 8'h02, 16'h0010, 1'b1, 1'b0, 1'b1);
      while (cyc_cnt < acc_n + 20) step();
      rst_n = 1'b0;
      step();
      check_reset_outputs("t8_reset");
      rst_n  = 1'b1;
      int_en = 1'b1;
      repeat (6) step();
      check("t8_no_rsp", {rsp_valid, log_q.size() - lbase}, {1'b0, 32'd5});

      // Recovery transfer
      send(32'h236F, 7'd4, 8'h01, 16'h0004, 1'b1, 1'b1, 1'b0);
      wait_rsp("t9");
      check("t9_rsp", {rsp_err, rsp_data}, {1'b0, 32'h0000_000F});
      check_xfer("t9", 32'h3C04, 32'h4, 32'h1, 32'h236F, 32'h3D04, 1'b1);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_xfer_sequencer.md
# spi_xfer_sequencer

Wishbone bus master that runs one complete SPI transfer on the `spi_top` core per request. Requests carry data, character length, slave select, clock divider and mode bits. The block configures the core in a fixed register order, then starts the shift, waits for the completion interrupt, reads back the receive word and returns it. It sits between a simple valid/ready client (firmware shim or DMA) and the `spi_top` Wishbone slave port, replacing hand-sequenced register writes.

## Interface

Parameters:
- `SS_NB`, 8: width of the slave-select field; matches `SPI_SS_NB` of the core.
- `TIMEOUT`, 4096: cycles allowed in WAIT_INT before the transfer is aborted with error.

Ports:
- `wb_clk_in` in 1: sole clock; all logic rises on its posedge.
- `wb_rst_in` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_data` in 32: TX0 word.
- `req_len` in 7: char_len; 0 means 128 bits.
- `req_ss` in SS_NB: slave-select mask written to SS register.
- `req_div` in 16: divider value.
- `req_lsb`, `req_tx_neg`, `req_rx_neg` in 1 each: CTRL mode bits.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: client takes result.
- `rsp_data` out 32: RX0 word read back; 0 on error.
- `rsp_err` out 1: timeout occurred; qualified by `rsp_valid`.
- `wb_adr_o` out 5, `wb_dat_o` out 32, `wb_sel_o` out 4, `wb_we_o` out 1, `wb_stb_o` out 1, `wb_cyc_o` out 1: Wishbone master outputs.
- `wb_dat_i` in 32, `wb_ack_i` in 1: Wishbone slave responses.
- `wb_int_i` in 1: core interrupt.

## Operation

- Request fields are latched on the `req_valid && req_ready` handshake. Later changes on `req_*` have no effect.
- CTRL base word = {18'b0, ass=1, ie=1, lsb, tx_neg, rx_neg, go=0, 1'b0, len}. Bits are: [13] ass, [12] ie, [11] lsb, [10] tx_neg, [9] rx_neg, [8] go, [6:0] char_len.
- State sequence:
  - IDLE
  - WR_CTRL (adr 0x10, base)
  - WR_DIV (0x14, {16'b0,div})
  - WR_SS (0x18, zero-extended ss)
  - WR_TX (0x00, data)
  - WR_GO (0x10, base | 0x100)
  - WAIT_INT
  - RD_RX (0x00, we=0)
  - RESP
  - back to IDLE
- Every bus cycle: `wb_sel_o`=4'hF. `cyc`, `stb` and `adr`/`dat`/`we` assert together and are held constant until `wb_ack_i`. On the ack cycle the FSM advances, and `cyc`/`stb` drop for at least one cycle before the next access.
- WAIT_INT: a counter increments from 0 each cycle. `wb_int_i`=1 moves to RD_RX. Counter reaching TIMEOUT-1 without the interrupt moves to RESP with `rsp_err`=1 and `rsp_data`=0, skipping RD_RX.
- RD_RX captures `wb_dat_i` on ack into `rsp_data`. That read also clears the core interrupt.
- RESP: `rsp_valid`=1. `rsp_data` and `rsp_err` are held stable until `rsp_ready`. On `rsp_valid && rsp_ready`, go to IDLE.
- No bus activity in IDLE, WAIT_INT or RESP.
- `wb_ack_i` outside an active cycle is ignored.
- `wb_int_i` outside WAIT_INT is ignored.

## Timing

- Reset values (when `wb_rst_in`=0 at a posedge):
  - state IDLE
  - `req_ready`=1
  - `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0
  - `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0, `wb_adr_o`=0, `wb_dat_o`=0, `wb_sel_o`=0
  - timeout counter 0
- Reset during any state, including mid bus cycle, drops `cyc`/`stb` on the following edge. The request is lost and no response is issued.
- `req_ready` drops in the cycle after the accept handshake. WR_CTRL `stb` is asserted that same cycle.
- With a zero-wait slave (ack one cycle after `stb`), each access takes 2 cycles active plus 1 idle. The five writes take 15 cycles from accept to WAIT_INT entry.
- `rsp_valid` rises 1 cycle after the RD_RX ack. On timeout, it rises 1 cycle after counter = TIMEOUT-1.
- A new request can be accepted in the cycle after the response handshake (`req_ready`=1 there). Back-to-back `req_valid` with `rsp_ready` tied high gives no lost cycle beyond that.

## Test plan

- Core config check: req len=4, data=0x236F, ss=1, div=4, lsb=1, tx_neg=1, rx_neg=0.
  - Required write sequence: 0x10←0x3C04, 0x14←0x4, 0x18←0x1, 0x00←0x236F, 0x10←0x3D04, then a read of 0x00.
  - `rsp_data` equals the slave model's returned bits; `rsp_err`=0.
- Mode variant: rx_neg=1, tx_neg=0 → CTRL writes 0x3A04 then 0x3B04. Response is correct against the loopback slave.
- Timeout: `wb_int_i` held 0, TIMEOUT=16.
  - `rsp_valid` 16 cycles after WAIT_INT entry with `rsp_err`=1, `rsp_data`=0.
  - No read access on the bus.
- Wait-state slave: ack delayed 3 cycles per access → `adr`/`dat`/`we` stable throughout each access; sequence and result unchanged.
- Backpressure and back-to-back: `rsp_ready` low for 5 cycles → `rsp_valid`/`rsp_data` held. Second request accepted the cycle after the handshake; `req_*` toggling mid-transfer does not alter written values.
- Reset mid-operation: assert reset during WR_TX and during WAIT_INT → next edge shows all outputs at reset values. A subsequent request completes normally.
